// File: rtl/ui_pkg.sv
// ============================================================================
// Module : ui_pkg
// Brief  : Shared FSM state encoding and debounce counter sizing for ui_control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ui_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int DBNC_W              = $clog2(DEBOUNCE_CYCLES_DEF + 1);

    // Counter width able to hold 0..cycles.
    function automatic int dbnc_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ui_key_edge.sv
// ============================================================================
// Module : ui_key_edge
// Brief  : Optional key debounce (UI_CTRL_DEBOUNCE_EN) followed by a rising-edge
//          detector producing a combinational single-cycle rise indication.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ui_key_edge
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = DBNC_W
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key,
    output logic o_rise
);

    logic w_level;
    logic r_prev;

`ifdef UI_CTRL_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (i_key != r_level) begin
            if (r_cnt == C_CNT_LAST) begin
                r_level <= i_key;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = i_key;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/ui_control.sv
// ============================================================================
// Module : ui_control
// Brief  : Key-to-strobe sequencer for the UI register bank and line drawer.
//          Optional key debounce enabled by defining UI_CTRL_DEBOUNCE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ui_control
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_setx,
    input  logic i_key_sety,
    input  logic i_key_setcol,
    input  logic i_key_go,
    input  logic i_done,
    output logic o_setx,
    output logic o_sety,
    output logic o_setcol,
    output logic o_reg_ld,
    output logic o_start,
    output logic o_busy,
    output logic o_first
);

    localparam int C_CNT_W = dbnc_width(DEBOUNCE_CYCLES);

    logic   w_rise_x, w_rise_y, w_rise_c, w_rise_go;
    logic   w_take_set;
    state_t r_state, w_state_nxt;
    logic   r_first, r_setx, r_sety, r_setcol;

    ui_key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(C_CNT_W)) u_edge_x (
        .i_clk(i_clk), .i_reset(i_reset), .i_key(i_key_setx),   .o_rise(w_rise_x)
    );
    ui_key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(C_CNT_W)) u_edge_y (
        .i_clk(i_clk), .i_reset(i_reset), .i_key(i_key_sety),   .o_rise(w_rise_y)
    );
    ui_key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(C_CNT_W)) u_edge_c (
        .i_clk(i_clk), .i_reset(i_reset), .i_key(i_key_setcol), .o_rise(w_rise_c)
    );
    ui_key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(C_CNT_W)) u_edge_go (
        .i_clk(i_clk), .i_reset(i_reset), .i_key(i_key_go),     .o_rise(w_rise_go)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise_go) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = r_first ? S_IDLE : S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (i_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // GO beats any set edge; set edges share one bus, so only the winner fires.
    assign w_take_set = (r_state == S_IDLE) && !w_rise_go;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_first  <= 1'b1;
            r_setx   <= 1'b0;
            r_sety   <= 1'b0;
            r_setcol <= 1'b0;
        end else begin
            if (r_state == S_LOAD) r_first <= 1'b0;
            r_setx   <= w_take_set && w_rise_x;
            r_sety   <= w_take_set && w_rise_y && !w_rise_x;
            r_setcol <= w_take_set && w_rise_c && !w_rise_x && !w_rise_y;
        end
    end

    assign o_setx   = r_setx;
    assign o_sety   = r_sety;
    assign o_setcol = r_setcol;
    assign o_reg_ld = (r_state == S_LOAD);
    assign o_start  = (r_state == S_START);
    assign o_busy   = (r_state != S_IDLE);
    assign o_first  = r_first;

endmodule

`default_nettype wire

// File: tb/tb_ui_control.sv
// ============================================================================
// Module : tb_ui_control
// Brief  : Randomized and directed self-checking bench for ui_control against a
//          cycle-level behavioural model. Honours UI_CTRL_DEBOUNCE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ui_control;

`ifdef UI_CTRL_DEBOUNCE_EN
    localparam int DBC = 4;
    localparam int LAT = 4;
`else
    localparam int DBC = 16;
    localparam int LAT = 0;
`endif
    localparam int HOLD = LAT + 3;
    localparam int GAP  = LAT + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, kx, ky, kc, kg, done;
    logic o_setx, o_sety, o_setcol, o_reg_ld, o_start, o_busy, o_first;

    ui_control #(.DEBOUNCE_CYCLES(DBC)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_key_setx(kx), .i_key_sety(ky), .i_key_setcol(kc), .i_key_go(kg),
        .i_done(done),
        .o_setx(o_setx), .o_sety(o_sety), .o_setcol(o_setcol),
        .o_reg_ld(o_reg_ld), .o_start(o_start), .o_busy(o_busy), .o_first(o_first)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: expected outputs for the current cycle plus key history.
    bit m_prev[4];
    bit m_filt[4];
    int m_cnt[4];
    bit m_first, m_ld, m_st, m_wt, m_setx, m_sety, m_setcol;
    int seen_setx, seen_sety, seen_setcol, seen_ld, seen_start, seen_busy;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = 1'b0;
            m_filt[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        m_first = 1'b1;
        {m_ld, m_st, m_wt, m_setx, m_sety, m_setcol} = '0;
    endtask

    // Check this cycle's outputs, drive the next inputs, advance the model one clock.
    task automatic step(input bit x, input bit y, input bit c, input bit g, input bit d, input bit r);
        bit raw[4];
        bit rise[4];
        bit lvl, idle;
        check("setx",   o_setx,   m_setx);
        check("sety",   o_sety,   m_sety);
        check("setcol", o_setcol, m_setcol);
        check("reg_ld", o_reg_ld, m_ld);
        check("start",  o_start,  m_st);
        check("busy",   o_busy,   m_ld | m_st | m_wt);
        check("first",  o_first,  m_first);
        seen_setx   += int'(o_setx);
        seen_sety   += int'(o_sety);
        seen_setcol += int'(o_setcol);
        seen_ld     += int'(o_reg_ld);
        seen_start  += int'(o_start);
        seen_busy   += int'(o_busy);

        kx = x; ky = y; kc = c; kg = g; done = d; rst = r;

        if (r) begin
            model_reset();
        end else begin
            raw = '{x, y, c, g};
            for (int i = 0; i < 4; i++) begin
`ifdef UI_CTRL_DEBOUNCE_EN
                lvl = m_filt[i];
                if (raw[i] != m_filt[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DBC) begin
                        m_filt[i] = raw[i];
                        m_cnt[i]  = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
`else
                lvl = raw[i];
`endif
                rise[i]   = lvl && !m_prev[i];
                m_prev[i] = lvl;
            end
            idle     = !(m_ld || m_st || m_wt);
            m_setx   = idle && !rise[3] && rise[0];
            m_sety   = idle && !rise[3] && !rise[0] && rise[1];
            m_setcol = idle && !rise[3] && !rise[0] && !rise[1] && rise[2];
            m_wt     = m_st || (m_wt && !d);
            m_st     = m_ld && !m_first;
            if (m_ld) m_first = 1'b0;
            m_ld     = idle && rise[3];
        end
        @(negedge clk);
    endtask

    task automatic hold(input bit x, input bit y, input bit c, input bit g, input bit d, input int n);
        for (int i = 0; i < n; i++) step(x, y, c, g, d, 1'b0);
    endtask

    int b0, b1, b2;
    bit rx, ry, rc, rg;

    initial begin
        rst = 1'b1; kx = 0; ky = 0; kc = 0; kg = 0; done = 0;
        {seen_setx, seen_sety, seen_setcol, seen_ld, seen_start, seen_busy} = '0;
        repeat (2) @(negedge clk);
        model_reset();

        // Held setx key: exactly one strobe.
        b0 = seen_setx;
        hold(1, 0, 0, 0, 0, LAT + 10);
        hold(0, 0, 0, 0, 0, GAP);
        check("hold_setx_once", seen_setx - b0, 1);

        // Simultaneous setx/sety: only setx fires.
        b0 = seen_setx; b1 = seen_sety;
        hold(1, 1, 0, 0, 0, HOLD);
        hold(0, 0, 0, 0, 0, GAP);
        check("pri_setx_once", seen_setx - b0, 1);
        check("pri_sety_none", seen_sety - b1, 0);

        // First GO: load only, busy one cycle.
        b0 = seen_ld; b1 = seen_start; b2 = seen_busy;
        hold(0, 0, 0, 1, 0, HOLD);
        hold(0, 0, 0, 0, 0, GAP);
        check("go1_ld",    seen_ld - b0, 1);
        check("go1_start", seen_start - b1, 0);
        check("go1_busy",  seen_busy - b2, 1);

        // Second GO: draw; setcol during WAIT ignored; done after 20 cycles.
        b0 = seen_start; b1 = seen_setcol;
        hold(0, 0, 0, 1, 0, HOLD);
        hold(0, 0, 1, 0, 0, HOLD);
        hold(0, 0, 0, 0, 0, 20);
        hold(0, 0, 0, 0, 1, 1);
        hold(0, 0, 0, 0, 0, GAP);
        check("go2_start",   seen_start - b0, 1);
        check("wait_setcol", seen_setcol - b1, 0);

        // Reset while waiting; following GO only loads.
        hold(0, 0, 0, 1, 0, HOLD);
        hold(0, 0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 1);
        hold(0, 0, 0, 0, 0, GAP);
        b0 = seen_ld; b1 = seen_start;
        hold(0, 0, 0, 1, 0, HOLD);
        hold(0, 0, 0, 0, 0, GAP);
        check("rst_go_ld",    seen_ld - b0, 1);
        check("rst_go_start", seen_start - b1, 0);

`ifdef UI_CTRL_DEBOUNCE_EN
        b0 = seen_setx;
        hold(1, 0, 0, 0, 0, 3);
        hold(0, 0, 0, 0, 0, 1);
        hold(1, 0, 0, 0, 0, 3);
        hold(0, 0, 0, 0, 0, GAP);
        check("dbnc_glitch", seen_setx - b0, 0);
        b0 = seen_setx;
        hold(1, 0, 0, 0, 0, 6);
        hold(0, 0, 0, 0, 0, GAP);
        check("dbnc_stable", seen_setx - b0, 1);
`endif

        // Randomized traffic against the model.
        {rx, ry, rc, rg} = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) rx = !rx;
            if ($urandom_range(7) == 0) ry = !ry;
            if ($urandom_range(7) == 0) rc = !rc;
            if ($urandom_range(9) == 0) rg = !rg;
            step(rx, ry, rc, rg, $urandom_range(9) == 0, $urandom_range(299) == 0);
        end
        step(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
